// File: rtl/spi_master_core.sv
// SPI initiator: one W-bit full-duplex word per start pulse, LSB first, clock idle low.
// The slave samples mosi on spi_clk rising edges; miso is captured on spi_clk falling edges.
module spi_master_core #(
  parameter int CLK_DIV = 4,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] tx_data,
  output logic [W-1:0] rx_data,
  output logic         busy,
  output logic         done,
  output logic         spi_clk,
  output logic         mosi,
  input  logic         miso,
  output logic         spi_ss
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [W-1:0]   shift_tx_q, shift_tx_d;
  logic [W-1:0]   shift_rx_q, shift_rx_d;
  logic [W-1:0]   rx_data_q, rx_data_d;
  logic           mosi_q, mosi_d;
  logic           spi_clk_q, spi_clk_d;
  logic           spi_ss_q, spi_ss_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           div_end;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    rx_data_d  = rx_data_q;
    mosi_d     = mosi_q;
    div_end    = (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETUP;
          shift_tx_d = tx_data;
          shift_rx_d = '0;
          bit_d      = '0;
          mosi_d     = tx_data[0];
        end
      end
      SETUP: begin
        if (div_end) state_d = HIGH;
      end
      HIGH: begin
        // Leaving HIGH is the falling edge: capture miso and present the next bit.
        if (div_end) begin
          state_d           = LOW;
          shift_rx_d[bit_q] = miso;
          if (bit_q != LAST_BIT) begin
            shift_tx_d = shift_tx_q >> 1;
            mosi_d     = shift_tx_q[1];
          end
        end
      end
      LOW: begin
        if (div_end) begin
          if (bit_q == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = HIGH;
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          state_d   = DONE;
          rx_data_d = shift_rx_q;
          mosi_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The divider restarts whenever the state changes.
    if ((state_d != state_q) || div_end) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    spi_clk_d = (state_d == HIGH);
    spi_ss_d  = !((state_d == SETUP) || (state_d == HIGH) ||
                  (state_d == LOW)   || (state_d == HOLD));
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      rx_data_q  <= '0;
      mosi_q     <= 1'b0;
      spi_clk_q  <= 1'b0;
      spi_ss_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      rx_data_q  <= rx_data_d;
      mosi_q     <= mosi_d;
      spi_clk_q  <= spi_clk_d;
      spi_ss_q   <= spi_ss_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign spi_clk = spi_clk_q;
  assign mosi    = mosi_q;
  assign spi_ss  = spi_ss_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core: two instances (CLK_DIV=4 and CLK_DIV=1), randomized words,
// every cycle compared against a timing model derived from the edge-position formulas.
module tb_spi_master_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         miso;
  logic [W-1:0] tx_data;
  logic         sel;

  logic [W-1:0] rx4, rx1;
  logic         busy4, busy1, done4, done1, sclk4, sclk1, mosi4, mosi1, ss4, ss1;

  logic [W-1:0] rx_data;
  logic         busy, done, spi_clk, mosi, spi_ss;

  int           num_checks = 0;
  int           num_fails  = 0;
  logic [W-1:0] exp_rx;

  always #5 clk = ~clk;

  spi_master_core #(.CLK_DIV(4), .W(W)) dut4 (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx4),
    .busy(busy4), .done(done4), .spi_clk(sclk4), .mosi(mosi4), .miso(miso), .spi_ss(ss4)
  );

  spi_master_core #(.CLK_DIV(1), .W(W)) dut1 (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx1),
    .busy(busy1), .done(done1), .spi_clk(sclk1), .mosi(mosi1), .miso(miso), .spi_ss(ss1)
  );

  assign rx_data = sel ? rx1   : rx4;
  assign busy    = sel ? busy1 : busy4;
  assign done    = sel ? done1 : done4;
  assign spi_clk = sel ? sclk1 : sclk4;
  assign mosi    = sel ? mosi1 : mosi4;
  assign spi_ss  = sel ? ss1   : ss4;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // spi_clk is high in the window [rise k, fall k) for some bit k
  function automatic logic expSpiClk(input int c, input int d);
    for (int k = 0; k < W; k++)
      if (c >= 1 + (2 * k + 1) * d && c < 1 + (2 * k + 2) * d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int fallsSoFar(input int c, input int d);
    int n = 0;
    for (int k = 0; k < W; k++)
      if (c >= 1 + (2 * k + 2) * d) n++;
    return n;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"}, 16'(busy), 16'd0);
    checkOutput({tag, " done"}, 16'(done), 16'd0);
    checkOutput({tag, " ss"}, 16'(spi_ss), 16'd1);
    checkOutput({tag, " sclk"}, 16'(spi_clk), 16'd0);
    checkOutput({tag, " mosi"}, 16'(mosi), 16'd0);
    checkOutput({tag, " rx"}, 16'(rx_data), 16'(exp_rx));
  endtask

  task automatic doReset();
    rst     = 1'b1;
    start   = 1'b0;
    miso    = 1'b0;
    tx_data = '0;
    repeat (2) @(negedge clk);
    exp_rx = '0;
    checkIdle("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one transfer starting at the current negedge (cycle 0) and checks every cycle.
  task automatic applyStimulus(input logic [W-1:0] tx, input logic [W-1:0] slave,
                               input bit hold_start, input bit chain, input string name);
    int   d    = sel ? 1 : 4;
    int   cd   = 1 + (2 * W + 2) * d;
    int   idx;
    int   rises = 0;
    logic prev_clk = 1'b0;
    logic exp_mosi;
    tx_data = tx;
    start   = 1'b1;
    miso    = slave[0];
    for (int c = 1; c <= cd; c++) begin
      @(negedge clk);
      idx      = fallsSoFar(c, d);
      if (idx > W - 1) idx = W - 1;
      exp_mosi = (c < cd) ? tx[idx] : 1'b0;
      checkOutput($sformatf("%s c%0d busy", name, c), 16'(busy), 16'd1);
      checkOutput($sformatf("%s c%0d ss", name, c), 16'(spi_ss), 16'(c == cd));
      checkOutput($sformatf("%s c%0d done", name, c), 16'(done), 16'(c == cd));
      checkOutput($sformatf("%s c%0d sclk", name, c), 16'(spi_clk), 16'(expSpiClk(c, d)));
      checkOutput($sformatf("%s c%0d mosi", name, c), 16'(mosi), 16'(exp_mosi));
      if (c == cd) exp_rx = slave;
      checkOutput($sformatf("%s c%0d rx", name, c), 16'(rx_data), 16'(exp_rx));
      if (spi_clk && !prev_clk) rises++;
      prev_clk = spi_clk;
      for (int k = 0; k < W - 1; k++)
        if (c == 1 + (2 * k + 2) * d) miso = slave[k+1];
      start   = hold_start;
      tx_data = W'($urandom);
    end
    checkOutput({name, " rise count"}, 16'(rises), 16'(W));
    @(negedge clk);
    checkIdle({name, " gap1"});
    if (!chain) begin
      start = 1'b0;
      @(negedge clk);
      checkIdle({name, " gap2"});
    end
  endtask

  // Starts a transfer and resets it after cycle rst_cycle; the abort must leave reset values only.
  task automatic applyAbort(input logic [W-1:0] tx, input int rst_cycle);
    int d  = sel ? 1 : 4;
    int cd = 1 + (2 * W + 2) * d;
    tx_data = tx;
    start   = 1'b1;
    miso    = 1'b1;
    for (int c = 1; c <= rst_cycle; c++) begin
      @(negedge clk);
      start = 1'b0;
      checkOutput($sformatf("abort c%0d sclk", c), 16'(spi_clk), 16'(expSpiClk(c, d)));
      checkOutput($sformatf("abort c%0d busy", c), 16'(busy), 16'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rx = '0;
    checkIdle("abort after rst");
    for (int c = 0; c < cd; c++) begin
      @(negedge clk);
      checkOutput($sformatf("abort quiet c%0d done", c), 16'(done), 16'd0);
      checkOutput($sformatf("abort quiet c%0d busy", c), 16'(busy), 16'd0);
    end
    checkOutput("abort rx held", 16'(rx_data), 16'(exp_rx));
  endtask

  initial begin
    sel = 1'b0;
    doReset();

    applyAbort(8'h5A, 21);
    applyStimulus(8'hA5, 8'h3C, 1'b0, 1'b0, "T1");
    applyStimulus(8'h12, W'($urandom), 1'b1, 1'b0, "T3");
    applyStimulus(8'h01, W'($urandom), 1'b1, 1'b1, "T5a");
    applyStimulus(8'h80, W'($urandom), 1'b1, 1'b0, "T5b");
    for (int i = 0; i < 6; i++)
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b0, $sformatf("R4_%0d", i));

    sel = 1'b1;
    doReset();
    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, "T6a");
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0, "T6b");
    applyStimulus(W'($urandom), W'($urandom), 1'b1, 1'b1, "B1a");
    applyStimulus(W'($urandom), W'($urandom), 1'b1, 1'b0, "B1b");
    for (int i = 0; i < 8; i++)
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b0, $sformatf("R1_%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
